// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional build macro ALU_ARB_STATS_EN adds saturating op/overflow counters (cnt0, cnt1, of_cnt).
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_res,
  output logic             resp0_car,
  output logic             resp0_of,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_res,
  output logic             resp1_car,
  output logic             resp1_of,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       of_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt;
  logic   owner_r;
  logic   last_grant_r;
  logic   grant_valid_s;
  logic   grant_s;
  logic   accept_s;
  logic   resp_hs_s;

  // Grant selection: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = ~last_grant_r;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  assign accept_s   = (state_r == IDLE) && grant_valid_s;
  assign req0_ready = accept_s && !grant_s;
  assign req1_ready = accept_s && grant_s;
  assign resp_hs_s  = (state_r == RESP) && (owner_r ? resp1_ready : resp0_ready);

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_hs_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  // Operand latch and ownership; ALU inputs hold their value outside of a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      alu_a        <= {WIDTH{1'b0}};
      alu_b        <= {WIDTH{1'b0}};
      alu_ctrl     <= {OP_W{1'b0}};
    end else if (accept_s) begin
      owner_r      <= grant_s;
      last_grant_r <= grant_s;
      alu_a        <= grant_s ? req1_a : req0_a;
      alu_b        <= grant_s ? req1_b : req0_b;
      alu_ctrl     <= grant_s ? req1_op : req0_op;
    end
  end

  // Result capture into the owner's response channel; data persists after valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp0_res   <= {WIDTH{1'b0}};
      resp0_car   <= 1'b0;
      resp0_of    <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_res   <= {WIDTH{1'b0}};
      resp1_car   <= 1'b0;
      resp1_of    <= 1'b0;
    end else if (state_r == EXEC) begin
      if (owner_r) begin
        resp1_valid <= 1'b1;
        resp1_res   <= alu_res;
        resp1_car   <= alu_car;
        resp1_of    <= alu_of;
      end else begin
        resp0_valid <= 1'b1;
        resp0_res   <= alu_res;
        resp0_car   <= alu_car;
        resp0_of    <= alu_of;
      end
    end else if (resp_hs_s) begin
      if (owner_r) begin
        resp1_valid <= 1'b0;
      end else begin
        resp0_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating completion and overflow counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0   <= 8'h00;
      cnt1   <= 8'h00;
      of_cnt <= 8'h00;
    end else begin
      if (resp_hs_s && !owner_r && (cnt0 != 8'hFF)) begin
        cnt0 <= cnt0 + 8'd1;
      end
      if (resp_hs_s && owner_r && (cnt1 != 8'hFF)) begin
        cnt1 <= cnt1 + 8'd1;
      end
      if ((state_r == EXEC) && alu_of && (of_cnt != 8'hFF)) begin
        of_cnt <= of_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU.
- The ALU datapath is combinational, with a 3-bit opcode (add, sub, not, and, or, xor, compare, equal) and outputs res, car and of.
- This block accepts operations over valid/ready, drives registered operands and opcode into the ALU, captures the result, and returns it on a per-requester response channel.
- It sits between the control logic (e.g. switch/key sequencer, test driver) and the ALU, so one ALU instance serves both clients.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- OP_W, 3, opcode width; must match the ALU ctrl.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- reqN_valid  input  1  request N (N=0,1) has an operation
- reqN_ready  output  1  request N accepted this cycle
- reqN_a  input  WIDTH  operand a
- reqN_b  input  WIDTH  operand b
- reqN_op  input  OP_W  ALU opcode
- respN_valid  output  1  response N holds a result
- respN_ready  input  1  requester N takes the result
- respN_res  output  WIDTH  captured ALU res
- respN_car  output  1  captured ALU car
- respN_of  output  1  captured ALU of
- alu_a  output  WIDTH  registered operand to ALU
- alu_b  output  WIDTH  registered operand to ALU
- alu_ctrl  output  OP_W  registered opcode to ALU
- alu_res  input  WIDTH  ALU result
- alu_car  input  1  ALU carry
- alu_of  input  1  ALU overflow
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - State IDLE; last_grant=1, so requester 0 wins first.
  - All reqN_ready, respN_valid and busy are 0.
  - alu_a, alu_b, alu_ctrl and all respN_res/car/of are 0.
- FSM, three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the requester with valid set; if both are valid, the one not equal to last_grant.
  - reqN_ready is combinational: (state==IDLE) && grant==N. At most one ready is asserted per cycle.
  - On handshake: latch a/b/op into alu_a/alu_b/alu_ctrl, record owner, set last_grant=owner, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU outputs settle from the registered operands.
  - At the clock edge, capture alu_res/car/of into resp<owner>_* and set resp<owner>_valid=1; go to RESP.
- RESP:
  - Hold respN_valid and data stable until respN_ready. On handshake, clear valid and go to IDLE.
  - No new request is accepted while in EXEC or RESP. Back-pressure on the response stalls both requesters.
- Latency: request handshake in cycle T, resp_valid in cycle T+2. Earliest next accept is T+3 if resp_ready was high in T+2. Peak throughput is one op per 3 cycles.
- Output hold:
  - alu_a/b/ctrl keep their last values outside EXEC (no glitching to 0).
  - respN data is held after valid drops, until overwritten.
- Requester obligations: a/b/op stay stable while valid && !ready, and valid is not withdrawn before ready. The arbiter does not check this.
- Opcode handling: passes through unmodified; all 8 codes are legal; no width extension (WIDTH-bit in/out).
- Reset mid-operation: asserting rst_n=0 in EXEC or RESP aborts the transaction immediately (async). All outputs take reset values, the result is lost, and the first grant after reset goes to requester 0.
- Simultaneous request and response: in RESP, respN_ready and a new reqM_valid in the same cycle → the response completes and the FSM enters IDLE. The request is granted in the next cycle, not the same one.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds outputs cnt0, cnt1 (8 bits each): completed ops per requester, incremented on the response handshake, saturating at 8'hFF.
  - Adds output of_cnt (8 bits): count of captured of=1, saturating.
  - All reset to 0.
- ALU_ARB_STATS_EN undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Single op: after reset, req0 a=4'h7 b=4'h1 op=3'b000 → req0_ready in T, alu_a=7/alu_b=1/alu_ctrl=0 in T+1, resp0_valid in T+2 with res=4'h8, car=0, of=1.
- Contention: req0 and req1 both valid continuously, resp_ready=1 → grants alternate 0,1,0,1; accepts spaced 3 cycles apart; each resp goes only to its owner.
- Response back-pressure: resp1_ready=0 for 5 cycles, req0 valid → resp1_valid and res stay stable; req0_ready stays 0 until 1 cycle after the resp1 handshake.
- Op pass-through: req1 a=4'hA b=4'h5 op=3'b101 (xor) → resp1 res=4'hF, car=0, of=0; op=3'b111 with a=b=4'h3 → res=0.
- Reset mid-op: assert rst_n=0 during EXEC → same cycle: respN_valid=0, busy=0, alu_* = 0; after release, both valid → requester 0 granted first.
- Stats (with ALU_ARB_STATS_EN): 300 ops from req0 → cnt0=8'hFF (saturated), cnt1=0, and of_cnt equals the number of of=1 results.
